// File: rtl/hdmi_pkg.sv
// Shared HDMI period definitions: encoder modes, control-period CTL codes
// and the fixed lengths of preambles, guard bands and packets.
package hdmi_pkg;

    // Encoder mode, also consumed by the per-channel TMDS encoders.
    typedef enum logic [2:0] {
        CONTROL      = 3'd0,
        VIDEO        = 3'd1,
        VIDEO_GUARD  = 3'd2,
        ISLAND       = 3'd3,
        ISLAND_GUARD = 3'd4
    } mode_t;

    // CTL3..CTL0 patterns sent during the two kinds of preamble.
    localparam logic [3:0] CTL_VIDEO_PRE  = 4'b0001;
    localparam logic [3:0] CTL_ISLAND_PRE = 4'b0101;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;

    // Data-island sequencing states.
    typedef enum logic [2:0] {
        S_CTRL,
        S_PRE,
        S_LGB,
        S_PKT,
        S_TGB
    } island_state_t;

endpackage

// File: rtl/hdmi_period_scheduler.sv
// Period scheduler for the three TMDS encoders: decodes video periods from
// the pixel position and places at most one data island per line in the
// horizontal blanking, committing packets from a single valid/ready source.
module hdmi_period_scheduler
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE    = 1280,
    parameter int H_TOTAL     = 1650,
    parameter int V_ACTIVE    = 720,
    parameter int V_TOTAL     = 750,
    parameter int ISLAND_GAP  = 4,
    parameter int MAX_PACKETS = 18,
    parameter int CX_W        = 11,
    parameter int CY_W        = 10
) (
    input  logic            clk_pixel,
    input  logic            reset,
    input  logic [CX_W-1:0] cx,
    input  logic [CY_W-1:0] cy,
    input  logic            pkt_valid,
    output logic            pkt_ready,
    output mode_t           mode,
    output logic [3:0]      ctl,
    output logic [4:0]      packet_pixel,
    output logic            island_first
);

    // A new packet may start only if packet, trailing guard, 4 plain control
    // cycles and the whole video preamble + guard still fit in the line.
    localparam int CONT_MARGIN  = PACKET_LEN + GUARD_LEN + 4 + PREAMBLE_LEN + GUARD_LEN;
    localparam int ISLAND_START = H_ACTIVE + ISLAND_GAP;
    localparam int CNT_W        = $clog2(MAX_PACKETS + 1);

    localparam logic [4:0] PRE_LAST   = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0] GUARD_LAST = 5'(GUARD_LEN - 1);
    localparam logic [4:0] PKT_LAST   = 5'(PACKET_LEN - 1);

    // An island entered at its start position must always fit one packet.
    if (ISLAND_START + PREAMBLE_LEN + GUARD_LEN + CONT_MARGIN > H_TOTAL) begin : g_bad_timing
        $error("hdmi_period_scheduler: blanking too short for one data island");
    end

    island_state_t    state;
    logic [4:0]       phase;
    logic [CNT_W-1:0] pkt_count;

    int    cx_i;
    int    cy_i;
    logic  next_active;
    logic  vid_hit;
    mode_t vid_mode;
    logic  [3:0] vid_ctl;
    logic  pkt_continue;

    assign cx_i = int'(cx);
    assign cy_i = int'(cy);

    // Video period decode and the packet continue decision for this position.
    always_comb begin
        vid_hit      = 1'b0;
        vid_mode     = CONTROL;
        vid_ctl      = 4'b0000;
        next_active  = (cy_i == V_TOTAL - 1) ? 1'b1 : (cy_i + 1 < V_ACTIVE);
        if (cx_i < H_ACTIVE && cy_i < V_ACTIVE) begin
            vid_hit  = 1'b1;
            vid_mode = VIDEO;
        end else if (next_active && cx_i >= H_TOTAL - 10 && cx_i <= H_TOTAL - 3) begin
            vid_hit  = 1'b1;
            vid_ctl  = CTL_VIDEO_PRE;
        end else if (next_active && cx_i >= H_TOTAL - 2) begin
            vid_hit  = 1'b1;
            vid_mode = VIDEO_GUARD;
        end
        pkt_continue = pkt_valid && (int'(pkt_count) < MAX_PACKETS)
                       && (cx_i + CONT_MARGIN <= H_TOTAL);
    end

    // Island FSM with registered outputs; each output describes the position
    // sampled on this edge. Video decode overrides the island if they overlap.
    // NOTE: every register here uses <= so all state updates see the same
    // pre-edge values; the later video override wins as the last assignment.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state        <= S_CTRL;
            phase        <= 5'd0;
            pkt_count    <= '0;
            mode         <= CONTROL;
            ctl          <= 4'b0000;
            pkt_ready    <= 1'b0;
            packet_pixel <= 5'd0;
            island_first <= 1'b0;
        end else begin
            mode         <= CONTROL;
            ctl          <= 4'b0000;
            pkt_ready    <= 1'b0;
            packet_pixel <= 5'd0;
            island_first <= 1'b0;
            case (state)
                S_CTRL: begin
                    if (pkt_valid && cx_i == ISLAND_START) begin
                        state     <= S_PRE;
                        phase     <= 5'd0;
                        pkt_count <= '0;
                        ctl       <= CTL_ISLAND_PRE;
                    end
                end
                S_PRE: begin
                    if (phase == PRE_LAST) begin
                        state <= S_LGB;
                        phase <= 5'd0;
                        mode  <= ISLAND_GUARD;
                    end else begin
                        phase <= phase + 5'd1;
                        ctl   <= CTL_ISLAND_PRE;
                    end
                end
                S_LGB: begin
                    if (phase == GUARD_LAST) begin
                        // The first packet is committed regardless of valid.
                        state        <= S_PKT;
                        phase        <= 5'd0;
                        pkt_count    <= CNT_W'(1);
                        pkt_ready    <= 1'b1;
                        island_first <= 1'b1;
                        mode         <= ISLAND;
                    end else begin
                        phase <= phase + 5'd1;
                        mode  <= ISLAND_GUARD;
                    end
                end
                S_PKT: begin
                    if (phase == PKT_LAST) begin
                        if (pkt_continue) begin
                            phase     <= 5'd0;
                            pkt_count <= pkt_count + CNT_W'(1);
                            pkt_ready <= 1'b1;
                            mode      <= ISLAND;
                        end else begin
                            state <= S_TGB;
                            phase <= 5'd0;
                            mode  <= ISLAND_GUARD;
                        end
                    end else begin
                        phase        <= phase + 5'd1;
                        packet_pixel <= phase + 5'd1;
                        mode         <= ISLAND;
                    end
                end
                S_TGB: begin
                    if (phase == GUARD_LAST) begin
                        state     <= S_CTRL;
                        phase     <= 5'd0;
                        pkt_count <= '0;
                    end else begin
                        phase <= phase + 5'd1;
                        mode  <= ISLAND_GUARD;
                    end
                end
                default: begin
                    state <= S_CTRL;
                    phase <= 5'd0;
                end
            endcase
            if (vid_hit) begin
                mode         <= vid_mode;
                ctl          <= vid_ctl;
                packet_pixel <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Scoreboard bench for hdmi_period_scheduler on 720p timing: the driver
// pushes the hand-derived expected outputs for each position it drives and
// a monitor pops and compares them one cycle later.
`timescale 1ns/1ps
module tb_hdmi_period_scheduler;
    import hdmi_pkg::*;

    localparam int CX_W = 11;
    localparam int CY_W = 10;

    typedef struct packed {
        logic [2:0] mode;
        logic [3:0] ctl;
        logic       rdy;
        logic [4:0] pix;
        logic       first;
    } out_t;

    typedef struct packed {
        int   x;
        int   y;
        out_t o;
    } exp_t;

    logic            clk_pixel = 1'b0;
    logic            reset = 1'b1;
    logic [CX_W-1:0] cx = '0;
    logic [CY_W-1:0] cy = '0;
    logic            pkt_valid = 1'b0;
    logic            valid3 = 1'b0;
    logic            pkt_ready, pkt_ready3;
    mode_t           mode, mode3;
    logic [3:0]      ctl, ctl3;
    logic [4:0]      packet_pixel, packet_pixel3;
    logic            island_first, island_first3;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t sb3[$];
    logic src_drop = 1'b0;

    hdmi_period_scheduler dut (
        .clk_pixel(clk_pixel), .reset(reset), .cx(cx), .cy(cy),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .mode(mode), .ctl(ctl),
        .packet_pixel(packet_pixel), .island_first(island_first)
    );

    hdmi_period_scheduler #(.MAX_PACKETS(3)) dut3 (
        .clk_pixel(clk_pixel), .reset(reset), .cx(cx), .cy(cy),
        .pkt_valid(valid3), .pkt_ready(pkt_ready3), .mode(mode3), .ctl(ctl3),
        .packet_pixel(packet_pixel3), .island_first(island_first3)
    );

    always #5 clk_pixel = ~clk_pixel;

    function automatic out_t got_main();
        out_t g;
        g.mode = mode; g.ctl = ctl; g.rdy = pkt_ready;
        g.pix = packet_pixel; g.first = island_first;
        return g;
    endfunction

    function automatic out_t got_max3();
        out_t g;
        g.mode = mode3; g.ctl = ctl3; g.rdy = pkt_ready3;
        g.pix = packet_pixel3; g.first = island_first3;
        return g;
    endfunction

    // Expected outputs for 720p: island starting at s (or none if s<0)
    // carrying n packets, then the fixed video timeline on top.
    function automatic exp_t expect_at(int x, int y, int s, int n);
        exp_t e;
        int   p0;
        int   pend;
        e.x = x; e.y = y; e.o = '0;
        p0   = s + 10;
        pend = p0 + 32 * n;
        if (s >= 0) begin
            if (x >= s && x < s + 8) e.o.ctl = 4'b0101;
            else if (x >= s + 8 && x < p0) e.o.mode = 3'd4;
            else if (x >= p0 && x < pend) begin
                e.o.mode  = 3'd3;
                e.o.pix   = 5'((x - p0) % 32);
                e.o.rdy   = ((x - p0) % 32) == 0;
                e.o.first = (x == p0);
            end else if (x >= pend && x < pend + 2) e.o.mode = 3'd4;
        end
        if (x < 1280 && y < 720) begin
            e.o = '0; e.o.mode = 3'd1;
        end else if (((y + 1) % 750) < 720 && x >= 1640 && x <= 1647) begin
            e.o = '0; e.o.ctl = 4'b0001;
        end else if (((y + 1) % 750) < 720 && x >= 1648) begin
            e.o = '0; e.o.mode = 3'd2;
        end
        return e;
    endfunction

    task automatic check(input string name, input int x, input int y, input out_t got, input out_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cy=%0d cx=%0d got mode=%0d ctl=%b rdy=%b pix=%0d first=%b want mode=%0d ctl=%b rdy=%b pix=%0d first=%b",
                     name, y, x, got.mode, got.ctl, got.rdy, got.pix, got.first,
                     want.mode, want.ctl, want.rdy, want.pix, want.first);
        end
    endtask

    // Drive one line span; v0 (0/1, -1 keep) sets pkt_valid at the span start,
    // rise raises it at that cx, drop mode retracts it after a seen pkt_ready.
    task automatic run_line(input int y, input int lo, input int hi, input int v0, input int rise,
                            input logic drop, input int s, input int n,
                            input logic chk3, input int s3, input int n3);
        src_drop = drop;
        for (int x = lo; x <= hi; x++) begin
            @(negedge clk_pixel);
            if (x == lo && v0 >= 0) pkt_valid = (v0 == 1);
            if (src_drop && pkt_ready) pkt_valid = 1'b0;
            if (x == rise) pkt_valid = 1'b1;
            valid3 = chk3;
            cx = CX_W'(x);
            cy = CY_W'(y);
            sb.push_back(expect_at(x, y, s, n));
            if (chk3) sb3.push_back(expect_at(x, y, s3, n3));
        end
    endtask

    // Monitor: outputs for the position driven on the previous negedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_pixel);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("main", e.x, e.y, got_main(), e.o);
            end
            if (sb3.size() > 0) begin
                e = sb3.pop_front();
                check("max3", e.x, e.y, got_max3(), e.o);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        out_t zero;
        zero = '0;
        repeat (3) @(posedge clk_pixel);
        #2;
        check("reset_main", 0, 0, got_main(), zero);
        check("reset_max3", 0, 0, got_max3(), zero);
        @(negedge clk_pixel);
        reset = 1'b0;

        // Plain video lines and vertical boundary lines.
        run_line(0,   0, 1649, 0, -1, 1'b0, -1, 0, 1'b0, -1, 0);
        run_line(719, 0, 1649, 0, -1, 1'b0, -1, 0, 1'b0, -1, 0);
        run_line(749, 0, 1649, 0, -1, 1'b0, -1, 0, 1'b0, -1, 0);
        // Single packet, valid retracted after the commit.
        run_line(725, 0, 1649, 1, -1, 1'b1, 1284, 1, 1'b0, -1, 0);
        // Valid held for the whole line: ten packets fit.
        run_line(726, 0, 1649, 1, -1, 1'b0, 1284, 10, 1'b0, -1, 0);
        // MAX_PACKETS=3 instance, two consecutive lines.
        run_line(727, 0, 1649, 0, -1, 1'b0, -1, 0, 1'b1, 1284, 3);
        run_line(728, 0, 1649, 0, -1, 1'b0, -1, 0, 1'b1, 1284, 3);
        // Late request waits for the next line.
        run_line(729, 0, 1649, 0, 1290, 1'b1, -1, 0, 1'b0, -1, 0);
        run_line(730, 0, 1649, -1, -1, 1'b1, 1284, 1, 1'b0, -1, 0);
        // Reset in the middle of the first packet.
        run_line(731, 0, 1305, 1, -1, 1'b0, 1284, 10, 1'b0, -1, 0);
        @(posedge clk_pixel);
        #3;
        reset = 1'b1;
        pkt_valid = 1'b0;
        #1;
        check("async_reset_main", 1305, 731, got_main(), zero);
        @(posedge clk_pixel);
        #1;
        check("reset_hold_main", 1305, 731, got_main(), zero);
        @(negedge clk_pixel);
        reset = 1'b0;
        run_line(731, 1306, 1649, 0, -1, 1'b0, -1, 0, 1'b0, -1, 0);
        run_line(732, 0, 1649, 1, -1, 1'b0, 1284, 10, 1'b0, -1, 0);

        @(posedge clk_pixel);
        #2;
        total++;
        if (sb.size() != 0 || sb3.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d pending want=0", sb.size(), sb3.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
